// File: rtl/mem_wb_skid_pkg.sv
// Shared widths, constants and occupancy encoding for the MEM/WB skid boundary.
// Imported by the interface, the payload register and the top.
package mem_wb_skid_pkg;

   localparam int InstAddrBus = 32;
   localparam int RegBus      = 32;
   localparam int RegAddrBus  = 5;
   localparam int StallCntBus = 16;

   localparam logic Enable  = 1'b1;
   localparam logic Disable = 1'b0;

   localparam logic [RegBus-1:0]     ZeroWord   = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

   // Skid occupancy never reaches "skid only": skid fills only behind a held main.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_MAIN  = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/mem_wb_skid_if.sv
// MEM -> WB handshake bundle: input payload, output payload, flush and stall count.
// The slave modport is the block's view; master is the pipeline/driver view.
interface mem_wb_skid_if
   import mem_wb_skid_pkg::*;
#(
   parameter int ADDR_W  = InstAddrBus,
   parameter int DATA_W  = RegBus,
   parameter int RADDR_W = RegAddrBus,
   parameter int CNT_W   = StallCntBus
) ();

   logic               flush_i;
   logic               in_valid_i;
   logic               in_ready_o;
   logic [ADDR_W-1:0]  pc_i;
   logic [RADDR_W-1:0] rw_i;
   logic               wreg_i;
   logic [DATA_W-1:0]  wdata_i;
   logic               whilo_i;
   logic [DATA_W-1:0]  hi_i;
   logic [DATA_W-1:0]  lo_i;

   logic               out_valid_o;
   logic               out_ready_i;
   logic [ADDR_W-1:0]  pc_o;
   logic [RADDR_W-1:0] rw_o;
   logic               wreg_o;
   logic [DATA_W-1:0]  wdata_o;
   logic               whilo_o;
   logic [DATA_W-1:0]  hi_o;
   logic [DATA_W-1:0]  lo_o;
   logic [CNT_W-1:0]   stall_cnt_o;

   modport slave (
      input  flush_i, in_valid_i, pc_i, rw_i, wreg_i, wdata_i, whilo_i, hi_i, lo_i,
      input  out_ready_i,
      output in_ready_o, out_valid_o, pc_o, rw_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o,
      output stall_cnt_o
   );

   modport master (
      output flush_i, in_valid_i, pc_i, rw_i, wreg_i, wdata_i, whilo_i, hi_i, lo_i,
      output out_ready_i,
      input  in_ready_o, out_valid_o, pc_o, rw_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o,
      input  stall_cnt_o
   );

endinterface

// File: rtl/mem_wb_skid_wb_payload_reg.sv
// Payload-wide register with load enable and synchronous clear (clear wins).
// Used for both the main and the skid entry.
module wb_payload_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (ld_i) data_d = d_i;
   end

   always_ff @(posedge clk) begin
      if (clr_i) data_q <= '0;
      else       data_q <= data_d;
   end

   assign q_o = data_q;

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB boundary with a 2-entry skid buffer, flush, bubble-gated write enables
// and a saturating back-pressure counter. in_ready_o is a pure register decode.
module mem_wb_skid
   import mem_wb_skid_pkg::*;
#(
   parameter int ADDR_W  = InstAddrBus,
   parameter int DATA_W  = RegBus,
   parameter int RADDR_W = RegAddrBus,
   parameter int CNT_W   = StallCntBus
) (
   input  logic          clk,
   input  logic          rst,
   mem_wb_skid_if.slave  bus
);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [RADDR_W-1:0] rw;
      logic               wreg;
      logic [DATA_W-1:0]  wdata;
      logic               whilo;
      logic [DATA_W-1:0]  hi;
      logic [DATA_W-1:0]  lo;
   } payload_t;

   localparam int PW = $bits(payload_t);

   occ_e             occ_q, occ_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   payload_t in_pl, main_q, skid_q, main_d;
   logic     main_ld, skid_ld, main_from_skid;
   logic     main_valid, skid_valid, accept, consume;

   assign main_valid = (occ_q != OCC_EMPTY);
   assign skid_valid = (occ_q == OCC_FULL);
   assign accept     = bus.in_valid_i & ~skid_valid;
   assign consume    = main_valid & bus.out_ready_i;

   assign in_pl = '{pc: bus.pc_i, rw: bus.rw_i, wreg: bus.wreg_i, wdata: bus.wdata_i,
                    whilo: bus.whilo_i, hi: bus.hi_i, lo: bus.lo_i};

   always_comb begin
      occ_d          = occ_q;
      main_ld        = Disable;
      skid_ld        = Disable;
      main_from_skid = Disable;
      if (bus.flush_i) begin
         occ_d = OCC_EMPTY;
      end else if (!main_valid || consume) begin
         if (skid_valid) begin
            // Skid drains into main; in_ready_o is low so nothing new arrives.
            main_ld        = Enable;
            main_from_skid = Enable;
            skid_ld        = accept;
            occ_d          = accept ? OCC_FULL : OCC_MAIN;
         end else begin
            main_ld = accept;
            occ_d   = accept ? OCC_MAIN : OCC_EMPTY;
         end
      end else if (accept) begin
         skid_ld = Enable;
         occ_d   = OCC_FULL;
      end
   end

   assign main_d = main_from_skid ? skid_q : in_pl;

   always_comb begin
      cnt_d = cnt_q;
      if (main_valid && !bus.out_ready_i && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= OCC_EMPTY;
         cnt_q <= '0;
      end else begin
         occ_q <= occ_d;
         cnt_q <= cnt_d;
      end
   end

   wb_payload_reg #(.W(PW)) u_main (
      .clk   (clk),
      .clr_i (rst),
      .ld_i  (main_ld),
      .d_i   (main_d),
      .q_o   (main_q)
   );

   wb_payload_reg #(.W(PW)) u_skid (
      .clk   (clk),
      .clr_i (rst),
      .ld_i  (skid_ld),
      .d_i   (in_pl),
      .q_o   (skid_q)
   );

   assign bus.in_ready_o  = ~skid_valid;
   assign bus.out_valid_o = main_valid;
   assign bus.pc_o        = main_q.pc;
   assign bus.rw_o        = main_q.rw;
   assign bus.wreg_o      = main_q.wreg & main_valid;
   assign bus.wdata_o     = main_q.wdata;
   assign bus.whilo_o     = main_q.whilo & main_valid;
   assign bus.hi_o        = main_q.hi;
   assign bus.lo_o        = main_q.lo;
   assign bus.stall_cnt_o = cnt_q;

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
Parametrised MEM/WB pipeline boundary, successor to the plain MEM/WB stage register. It carries the register-file and HI/LO write-back payload across a valid/ready handshake. A 2-entry skid buffer keeps the register-file write path timing-clean when write-back back-pressures. Adds flush, write-enable gating by valid, and a saturating back-pressure counter.

Parameters:
ADDR_W, 32, PC width
DATA_W, 32, width of wdata, hi and lo
RADDR_W, 5, register-file address width
CNT_W, 16, width of the back-pressure counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high (1 = reset)
flush_i  in  1  discard all held entries this cycle
in_valid_i  in  1  MEM stage presents a payload
in_ready_o  out  1  block can accept a payload
pc_i  in  ADDR_W  instruction PC
rw_i  in  RADDR_W  destination register
wreg_i  in  1  register-file write enable
wdata_i  in  DATA_W  register write data
whilo_i  in  1  HI/LO write enable
hi_i  in  DATA_W  HI data
lo_i  in  DATA_W  LO data
out_valid_o  out  1  payload valid toward write-back
out_ready_i  in  1  write-back consumes the payload
pc_o, rw_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o  out  as inputs  registered payload
stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating

Behaviour:
- Storage is two entries: main (drives the outputs) and skid. Each entry has a valid bit.
- Reset (rst=1 at an edge): both valid bits = 0, all payload outputs = 0, rw_o = 0 (NOP register), stall_cnt_o = 0. Reset overrides flush and all handshakes.
- in_ready_o = !skid_valid. It is a registered signal with no combinational path from out_ready_i.
- Accept = in_valid_i & in_ready_o. Consume = out_valid_o & out_ready_i. out_valid_o = main_valid.
- Latency: an accepted payload appears on the outputs one cycle later when the main entry is empty or is being consumed.
- Transitions, in order of priority:
  - flush_i=1: both valid bits cleared next cycle. Any accept in the same cycle is dropped. Payload registers may hold stale data. stall_cnt is not reset.
  - Main empty or consumed, and skid valid: main <= skid. Skid takes the new accept, or else clears.
  - Main empty or consumed, skid empty: main <= input if accept, else main_valid <= 0.
  - Main held (valid and not consumed): an accept goes to skid. It cannot occur while skid is already valid, because in_ready_o=0 then.
- wreg_o and whilo_o are gated with main_valid. When out_valid_o=0, both read 0, so write-back never writes on a bubble.
- Payload order is strictly FIFO. Simultaneous accept and consume with a full main and empty skid is a pass-through: main gets the new payload and skid stays empty.
- stall_cnt_o increments when out_valid_o & !out_ready_i, and saturates at all-ones.
- Reset arriving mid-stall discards both entries. in_ready_o returns to 1 the cycle after reset deasserts.

Decomposition:
- Shared package/defines: ZeroWord, NOPRegAddr, Enable/Disable, and the default widths (InstAddrBus, RegBus, RegAddrBus widths).
- One natural sub-module: wb_payload_reg, a payload-wide register with load enable and synchronous clear. It is instantiated twice, for main and skid.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid_i=1 → out_valid_o=0, wreg_o=0, rw_o=0, stall_cnt_o=0, in_ready_o=1 the cycle after release.
- Streaming: out_ready_i=1, payloads pc=0x100/0x104/0x108 on consecutive cycles → each appears one cycle later, in_ready_o stays 1, stall_cnt_o=0.
- Back-pressure: hold out_ready_i=0 while sending pc=0x200 and 0x204 → out shows 0x200, in_ready_o=0 after the second accept; release → 0x200, then 0x204 in order, stall_cnt_o equals the cycles held.
- Bubble gating: in_valid_i=0 with wreg_i=1, whilo_i=1 → wreg_o=0, whilo_o=0, out_valid_o=0.
- Flush while full: both entries valid, flush_i=1 with in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1, and the flushed and incoming payloads never appear.
- Saturation: CNT_W=4, hold out_valid_o=1 and out_ready_i=0 for 20 cycles → stall_cnt_o=15.
